// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the CPU load/store unit (port 0)
// and the debug/loader port (port 1). The memory reads combinationally and
// writes on the rising clock edge, so the request-to-memory path here is purely
// combinational, while the response path is registered: every accepted
// transfer produces a one-cycle rsp_valid pulse on its own port in the
// following cycle.
//
// Arbitration is round-robin. A requester may hold the grant across several
// transfers by raising lock; the hold is bounded to MAX_LOCK cycles counted
// from the first locked acceptance, and the counter keeps running while the
// owner is idle, so the other port can never be starved indefinitely.
//
// Handshake: a request transfers in a cycle where rK_valid and rK_ready are
// both high. rK_ready is combinational and never depends on rK_ready of the
// other port. The requester must hold valid and payload stable until ready;
// this is assumed, not checked.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rK_valid / rK_ready      request handshake (K = 0, 1)
//   rK_we, rK_funct3         store flag and access size, forwarded unchanged
//   rK_addr, rK_wdata        byte address and store data
//   rK_lock                  keep the grant after this transfer
//   rK_rsp_valid             response pulse, one cycle after acceptance
//   rK_rsp_rdata             load data; 0 for stores and idle ports
//   mem_we, mem_funct3,
//   mem_addr, mem_wdata      memory request, all 0 when nothing is accepted
//   mem_rdata                combinational memory read data
//   dbg_lock_state_o         current lock ownership state (debug only)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_we,
  input  logic [2:0]  r0_funct3,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r0_lock,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_rdata,

  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_we,
  input  logic [2:0]  r1_funct3,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic        r1_lock,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_rdata,

  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  dbg_lock_state_o
);

  // Lock ownership is the only real state machine in the block.
  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_P0   = 2'b01,
    LOCK_P1   = 2'b10
  } lock_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);
  // With MAX_LOCK = 1 the first locked acceptance already uses the whole
  // budget, so a lock is never actually held.
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  lock_e       lock_q, lock_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        last_q, last_d;
  logic [1:0]  rsp_pend_q, rsp_pend_d;
  logic        rsp_we_q, rsp_we_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        grant;     // 0 = port 0, 1 = port 1
  logic        accept;
  logic        gnt_lock;
  logic [7:0]  lock_cnt_inc;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 1'b0;
    if (lock_q == LOCK_P0) begin
      grant = 1'b0;
    end else if (lock_q == LOCK_P1) begin
      grant = 1'b1;
    end else if (r0_valid && r1_valid) begin
      // Tie: the port that was not served last wins.
      grant = ~last_q;
    end else if (r1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  assign r0_ready = r0_valid & ~grant;
  assign r1_ready = r1_valid &  grant;
  assign accept   = r0_ready | r1_ready;
  assign gnt_lock = grant ? r1_lock : r0_lock;

  // ---------------------------------------------------------------------------
  // Memory request mux; quiet (all zero) when nothing is accepted
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we     = 1'b0;
    mem_funct3 = 3'd0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    if (r0_ready) begin
      mem_we     = r0_we;
      mem_funct3 = r0_funct3;
      mem_addr   = r0_addr;
      mem_wdata  = r0_wdata;
    end else if (r1_ready) begin
      mem_we     = r1_we;
      mem_funct3 = r1_funct3;
      mem_addr   = r1_addr;
      mem_wdata  = r1_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock / round-robin next state
  // ---------------------------------------------------------------------------
  assign lock_cnt_inc = lock_cnt_q + 8'd1;

  always_comb begin
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    last_d     = last_q;

    if (accept) begin
      last_d = grant;
    end

    if (lock_q != LOCK_NONE) begin
      // The budget runs every cycle, idle or not. Reaching the budget and an
      // unlocked owner transfer both release; the owner's transfer in the
      // releasing cycle is still accepted above.
      lock_cnt_d = lock_cnt_inc;
      if ((accept && !gnt_lock) || (lock_cnt_inc >= MAX_CNT)) begin
        lock_d     = LOCK_NONE;
        lock_cnt_d = 8'd0;
        // Owner counts as last served so the other port wins the next tie.
        last_d     = (lock_q == LOCK_P1);
      end
    end else if (LOCK_EN && accept && gnt_lock) begin
      lock_d     = grant ? LOCK_P1 : LOCK_P0;
      lock_cnt_d = 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture: read data is sampled at the accept edge
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_pend_d = {r1_ready, r0_ready};
    rsp_we_d   = accept & mem_we;
    rsp_data_d = 32'd0;
    if (accept && !mem_we) begin
      rsp_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= LOCK_NONE;
      lock_cnt_q <= 8'd0;
      last_q     <= 1'b1;
      rsp_pend_q <= 2'b00;
      rsp_we_q   <= 1'b0;
      rsp_data_q <= 32'd0;
    end else begin
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_we_q   <= rsp_we_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response outputs; a port that is not responding shows zero data
  // ---------------------------------------------------------------------------
  assign r0_rsp_valid = rsp_pend_q[0];
  assign r1_rsp_valid = rsp_pend_q[1];
  assign r0_rsp_rdata = (rsp_pend_q[0] && !rsp_we_q) ? rsp_data_q : 32'd0;
  assign r1_rsp_rdata = (rsp_pend_q[1] && !rsp_we_q) ? rsp_data_q : 32'd0;

  assign dbg_lock_state_o = lock_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int MAXL = 4;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
  } req_t;

  typedef struct {
    logic        rst;
    req_t        p0;
    req_t        p1;
    logic [1:0]  e_rdy;   // {r1, r0}
    logic [1:0]  e_rv;    // {r1, r0}
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  localparam req_t IDLE = '0;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r0_valid, r0_ready, r0_we, r0_lock, r0_rsp_valid;
  logic [2:0]  r0_funct3;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_lock, r1_rsp_valid;
  logic [2:0]  r1_funct3;
  logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_lock_state;

  dmem_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_funct3(r0_funct3),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_funct3(r1_funct3),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_lock_state_o(dbg_lock_state)
  );

  // ---------------------------------------------------------------------------
  // Data memory device: 64 words, combinational read, byte-lane writes
  // ---------------------------------------------------------------------------
  logic [31:0] dev_mem [0:63];
  logic        mem_clr = 1'b1;

  assign mem_rdata = dev_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= 32'd0;
    end else if (mem_we) begin
      case (mem_funct3[1:0])
        2'd0:    dev_mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        2'd1:    dev_mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: dev_mem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];          // {rsp1_v, rsp0_v, rdata} for the next cycle
  logic [7:0]  ref_mem [int];     // byte-addressed shadow memory
  int   m_last, m_owner, m_age;   // last served, lock owner (-1 none), lock age
  req_t cur0, cur1;
  logic acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a[7:0]) & 32'hFC;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_byte(base + b);
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    for (int b = 0; b < n; b++) ref_mem[int'(a[7:0]) + b] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_owner = -1;
    m_age   = 0;
    exp_q.delete();
    exp_q.push_back(34'd0);
  endtask

  task automatic drive(input req_t a, input req_t b);
    cur0 = a;
    cur1 = b;
    r0_valid = a.v; r0_we = a.we; r0_funct3 = a.f3; r0_addr = a.addr;
    r0_wdata = a.wdata; r0_lock = a.lock;
    r1_valid = b.v; r1_we = b.we; r1_funct3 = b.f3; r1_addr = b.addr;
    r1_wdata = b.wdata; r1_lock = b.lock;
  endtask

  // Called between edges: checks every output against the model, then
  // advances the model across the coming edge.
  task automatic cycle_check(input string tag);
    int   g;
    logic acc;
    req_t rq;
    logic [33:0] e;
    logic [31:0] ed;

    if (rst) begin
      chk({tag, " rst r0_ready"}, {31'd0, r0_ready}, 32'd0);
      chk({tag, " rst r1_ready"}, {31'd0, r1_ready}, 32'd0);
      chk({tag, " rst rsp_valid"}, {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
      chk({tag, " rst rsp0_rdata"}, r0_rsp_rdata, 32'd0);
      chk({tag, " rst rsp1_rdata"}, r1_rsp_rdata, 32'd0);
      chk({tag, " rst mem_addr"}, mem_addr, 32'd0);
      chk({tag, " rst mem_we"}, {31'd0, mem_we}, 32'd0);
      acc0 = 1'b0;
      acc1 = 1'b0;
      model_reset();
      return;
    end

    g = -1;
    if (m_owner >= 0)            g = m_owner;
    else if (cur0.v && cur1.v)   g = 1 - m_last;
    else if (cur0.v)             g = 0;
    else if (cur1.v)             g = 1;
    acc  = (g == 0 && cur0.v) || (g == 1 && cur1.v);
    acc0 = acc && (g == 0);
    acc1 = acc && (g == 1);
    rq   = acc1 ? cur1 : (acc0 ? cur0 : IDLE);

    chk({tag, " r0_ready"}, {31'd0, r0_ready}, {31'd0, acc0});
    chk({tag, " r1_ready"}, {31'd0, r1_ready}, {31'd0, acc1});
    chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, rq.we});
    chk({tag, " mem_funct3"}, {29'd0, mem_funct3}, {29'd0, rq.f3});
    chk({tag, " mem_addr"}, mem_addr, rq.addr);
    chk({tag, " mem_wdata"}, mem_wdata, rq.wdata);

    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: expected-response queue empty", tag);
      e = 34'd0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, " rsp0_valid"}, {31'd0, r0_rsp_valid}, {31'd0, e[32]});
    chk({tag, " rsp1_valid"}, {31'd0, r1_rsp_valid}, {31'd0, e[33]});
    chk({tag, " rsp0_rdata"}, r0_rsp_rdata, e[32] ? e[31:0] : 32'd0);
    chk({tag, " rsp1_rdata"}, r1_rsp_rdata, e[33] ? e[31:0] : 32'd0);

    ed = (acc && !rq.we) ? ref_word(rq.addr) : 32'd0;
    exp_q.push_back({acc1, acc0, ed});
    if (acc && rq.we) ref_store(rq.addr, rq.f3, rq.wdata);

    if (m_owner >= 0) begin
      m_age++;
      if ((acc && !rq.lock) || m_age >= MAXL) begin
        m_owner = -1;
        m_age   = 0;
      end
    end else if (acc && rq.lock && MAXL > 1) begin
      m_owner = g;
      m_age   = 1;
    end
    if (acc) m_last = g;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic req_t rq_mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic l);
    req_t r;
    r = '{v: 1'b1, we: we, f3: f3, addr: a, wdata: d, lock: l};
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input req_t a, input req_t b, input logic [1:0] rdy,
                              input logic [1:0] rv, input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v = '{rst: r, p0: a, p1: b, e_rdy: rdy, e_rv: rv, e_rd0: d0, e_rd1: d1};
    return v;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [2:0] f3;
    logic [31:0] a;
    r = IDLE;
    if ($urandom_range(0, 3) == 0) return r;
    f3 = 3'($urandom_range(0, 2));
    a  = 32'($urandom_range(0, 63));
    a  = a & ~((32'd1 << f3) - 32'd1);
    if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
    r.v     = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.f3    = f3;
    r.addr  = a;
    r.wdata = $urandom;
    r.lock  = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  vec_t tbl[$];

  initial begin
    req_t L0, L1, L20, LK0, q0, q1;
    vec_t v;

    drive(IDLE, IDLE);
    model_reset();

    L0  = rq_mk(1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    L1  = rq_mk(1'b0, 3'd2, 32'h14, 32'd0, 1'b0);
    L20 = rq_mk(1'b0, 3'd2, 32'h20, 32'd0, 1'b0);
    LK0 = rq_mk(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);

    // Reset, idle, store then load on port 0
    tbl.push_back(mk(1, IDLE, IDLE, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, IDLE, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, rq_mk(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0), IDLE, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, L0, IDLE, 2'b01, 2'b01, 0, 0));
    tbl.push_back(mk(0, IDLE, rq_mk(1, 3'd2, 32'h14, 32'h1234_5678, 0), 2'b10, 2'b01, 32'hDEAD_BEEF, 0));
    // Reset while the port-1 store response is pending: no pulse
    tbl.push_back(mk(1, IDLE, IDLE, 2'b00, 2'b00, 0, 0));
    // Both ports loading continuously: 0,1,0,1
    tbl.push_back(mk(0, L0, L1, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, L0, L1, 2'b10, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, L0, L1, 2'b01, 2'b10, 0, 32'h1234_5678));
    tbl.push_back(mk(0, L0, L1, 2'b10, 2'b01, 32'hDEAD_BEEF, 0));
    // Clear word 0x20 from port 0, then a two-beat locked byte sequence on port 1
    tbl.push_back(mk(0, rq_mk(1, 3'd2, 32'h20, 32'd0, 0), IDLE, 2'b01, 2'b10, 0, 32'h1234_5678));
    tbl.push_back(mk(0, L20, rq_mk(1, 3'd0, 32'h21, 32'hAB, 1), 2'b10, 2'b01, 0, 0));
    tbl.push_back(mk(0, L20, rq_mk(1, 3'd0, 32'h22, 32'hCD, 0), 2'b10, 2'b10, 0, 0));
    tbl.push_back(mk(0, L20, IDLE, 2'b01, 2'b10, 0, 0));
    tbl.push_back(mk(0, IDLE, IDLE, 2'b00, 2'b01, 32'h00CD_AB00, 0));
    // Port 1 served last, then port 0 locks every transfer against busy port 1
    tbl.push_back(mk(0, IDLE, L1, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(0, LK0, L1, 2'b01, 2'b10, 0, 32'h1234_5678));
    tbl.push_back(mk(0, LK0, L1, 2'b01, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, LK0, L1, 2'b01, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, LK0, L1, 2'b01, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, LK0, L1, 2'b10, 2'b01, 32'hDEAD_BEEF, 0));
    // Port 0 locks then goes idle: port 1 waits out the budget
    tbl.push_back(mk(0, LK0, L1, 2'b01, 2'b10, 0, 32'h1234_5678));
    tbl.push_back(mk(0, IDLE, L1, 2'b00, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, IDLE, L1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, L1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, L1, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, IDLE, 2'b00, 2'b10, 0, 32'h1234_5678));
    // Reset right after a locked load: no pulse, port 0 wins the next tie
    tbl.push_back(mk(0, LK0, IDLE, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(1, IDLE, IDLE, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, L0, L1, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, L1, 2'b10, 2'b01, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, IDLE, IDLE, 2'b00, 2'b10, 0, 32'h1234_5678));
    // LED address is forwarded like any other
    tbl.push_back(mk(0, rq_mk(1, 3'd2, 32'h8000_0000, 32'h1, 0), IDLE, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, IDLE, IDLE, 2'b00, 2'b01, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (i != 0) @(posedge clk);
      #1;
      rst     = v.rst;
      mem_clr = (i == 0);
      drive(v.p0, v.p1);
      @(negedge clk);
      cycle_check($sformatf("row%0d", i));
      chk($sformatf("row%0d tbl ready", i), {30'd0, r1_ready, r0_ready}, {30'd0, v.e_rdy});
      chk($sformatf("row%0d tbl rsp_valid", i), {30'd0, r1_rsp_valid, r0_rsp_valid}, {30'd0, v.e_rv});
      chk($sformatf("row%0d tbl rsp0_rdata", i), r0_rsp_rdata, v.e_rd0);
      chk($sformatf("row%0d tbl rsp1_rdata", i), r1_rsp_rdata, v.e_rd1);
    end

    // Random traffic; requests are held until accepted
    q0 = IDLE;
    q1 = IDLE;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        q0  = IDLE;
        q1  = IDLE;
      end else begin
        rst = 1'b0;
        if (!q0.v || acc0) q0 = rand_req();
        if (!q1.v || acc1) q1 = rand_req();
      end
      drive(q0, q1);
      @(negedge clk);
      cycle_check($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU load/store unit (port 0) and the debug/loader port (port 1). Sits directly in front of the data memory, which reads combinationally and writes on the rising clock edge. Arbitration is round-robin with an optional bounded lock for atomic multi-beat sequences. The arbiter registers read data so each requester sees a one-cycle response.

## Interface
- MAX_LOCK, default 8: maximum consecutive cycles a lock may hold the grant, counted from the first locked acceptance; range 1..255.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- r0_valid / r1_valid  input  1  request valid
- r0_ready / r1_ready  output  1  request accepted this cycle (combinational)
- r0_we / r1_we  input  1  1 = store, 0 = load
- r0_funct3 / r1_funct3  input  3  access size, passed to memory unchanged
- r0_addr / r1_addr  input  32  byte address
- r0_wdata / r1_wdata  input  32  store data
- r0_lock / r1_lock  input  1  keep the grant after this transfer
- r0_rsp_valid / r1_rsp_valid  output  1  response pulse
- r0_rsp_rdata / r1_rsp_rdata  output  32  load data; 0 for stores
- mem_we  output  1  memory write enable
- mem_funct3  output  3  memory access size
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  combinational memory read data

## Operation
- State: `last` (last granted port), `lock_own` (none/0/1), `lock_cnt` (8 bits), `rsp_pend[1:0]`, `rsp_we`, `rsp_data`.
- Grant, evaluated combinationally each cycle:
  - If a lock is held by port k, grant = k. The other port gets ready = 0 even if port k is idle.
  - Otherwise, if exactly one port is valid, grant goes to that port.
  - Otherwise, if both ports are valid, grant goes to the port that is not `last`.
- rK_ready = valid & grant. At most one ready is high per cycle.
- Accepted transfer: mem_we = we; mem_funct3, mem_addr and mem_wdata come from the granted port.
- No acceptance: all mem_* outputs are 0.
- `last` updates to the accepted port on every acceptance.
- Lock set: an accepted transfer from port k with lock = 1 and no lock held sets lock_own = k and lock_cnt = 1.
- Lock while held:
  - lock_cnt increments every cycle, including idle cycles.
  - The lock releases after an accepted owner transfer with lock = 0.
  - The lock also releases when lock_cnt reaches MAX_LOCK; the owner's transfer in that cycle is still accepted.
  - On release, `last` = owner, so the other port wins the next tie.
- Response: every accepted transfer produces rsp_valid on its port the next cycle.
  - Loads: rsp_rdata = mem_rdata sampled at the accept edge.
  - Stores: rsp_rdata = 0.
  - Non-responding ports hold rsp_rdata at 0.
- The arbiter does not decode MMIO. The 0x8000_0000 LED address is forwarded to memory like any other address.

## Timing
- Reset values:
  - r0_ready = r1_ready = 0 (no valid inputs during reset)
  - r0_rsp_valid = r1_rsp_valid = 0
  - r0_rsp_rdata = r1_rsp_rdata = 0
  - mem_* = 0
  - last = 1, so port 0 wins the first tie
  - lock_own = none, lock_cnt = 0
- Reset mid-lock or mid-response clears the lock and drops the pending response with no rsp pulse.
- Latency: accept in cycle N, store committed at the N→N+1 edge, rsp_valid high for exactly cycle N+1.
- Throughput: one transfer per cycle total; back-to-back transfers from the same or alternating ports are allowed.
- A load issued the cycle after a store to the same address returns the new data.
- The memory-side path is combinational from the rK inputs; the response path is registered.
- Requesters must hold valid and payload stable until ready; the arbiter does not check this.

## Test plan
- Reset then idle: all outputs 0. Drive r0 sw 0x10 ← 0xDEADBEEF, then r0 lw 0x10 → r0_rsp_valid at N+1 with rdata 0xDEADBEEF; r1_rsp_valid stays 0.
- Both ports valid continuously with loads:
  - Grants alternate 0, 1, 0, 1 starting with port 0.
  - Responses appear on matching ports one cycle later, with no cycle lost.
- r1 sb 0x21 ← 0xAB with lock = 1, then sb 0x22 ← 0xCD with lock = 0, while r0 is valid:
  - r0_ready = 0 for both cycles.
  - r0 is granted in the third cycle and lw 0x20 returns byte1 = 0xAB, byte2 = 0xCD.
- MAX_LOCK = 4, r0 holds lock = 1 on every transfer, r1 valid throughout:
  - r0 gets exactly 4 grants.
  - r1 is granted in cycle 5.
- Lock held by r0, r0 idle, r1 valid: r1_ready stays 0 until lock_cnt reaches MAX_LOCK, then r1 is granted.
- Assert rst the cycle after an accepted load under lock:
  - No rsp_valid pulse.
  - After release, port 0 wins the first tie.
